debounce_fsm: RTL and testbench
===============================

Name: debounce_fsm

Overview:
- Debounce controller downstream of timer_dp.
- Synchronizes a raw mechanical switch input and consumes the periodic `done` tick from timer_dp as its sampling strobe.
- Drives timer_dp's `reset` input so the timer runs only while a transition is being qualified.
- Produces a clean level plus one-cycle rise and fall pulses for downstream control logic.

Parameters:
- N_TICKS, 4: consecutive timer ticks the synchronized input must stay stable before the output level changes; legal range ≥1.
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer; legal range ≥2.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset; low forces all state and outputs to reset values immediately.
- sw  input  1  raw, asynchronous, bouncing switch input.
- tick  input  1  one-cycle strobe from timer_dp `done`.
- timer_rst  output  1  to timer_dp `reset`; high holds the timer at zero.
- db_level  output  1  debounced switch level.
- db_rise  output  1  one-cycle pulse on a debounced 0→1 change.
- db_fall  output  1  one-cycle pulse on a debounced 1→0 change.

Behaviour:
Reset values:
- reset low: synchronizer chain = 0, state = ZERO, counter = 0.
- db_level = 0, db_rise = 0, db_fall = 0, timer_rst = 1.

Synchronizer:
- sw passes through SYNC_STAGES flops to give sw_s.
- sw_s is the only form of sw used by the FSM.

FSM states and transitions (evaluated each clk edge):
- ZERO: if sw_s = 1, go to WAIT1 and load cnt = N_TICKS-1. tick is ignored.
- WAIT1:
  - if sw_s = 0, go to ZERO (bounce abort); this has priority over a simultaneous tick.
  - else if tick and cnt = 0, go to ONE.
  - else if tick, cnt decrements.
- ONE: if sw_s = 0, go to WAIT0 and load cnt = N_TICKS-1. tick is ignored.
- WAIT0: mirror of WAIT1 with polarities swapped; abort returns to ONE, completion goes to ZERO.

Outputs (all registered, no combinational path from sw or tick):
- timer_rst = 1 in ZERO and ONE, 0 in WAIT1 and WAIT0; registered from the next-state decode.
  - The timer starts counting from 0 on the first WAIT cycle.
  - On abort or completion, timer_rst returns to 1 on the same edge the state leaves WAIT.
- db_level = 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
  - It updates on the same edge as the WAIT→stable transition.
- db_rise: high for exactly the one cycle following the WAIT1→ONE transition edge.
- db_fall: high for exactly the one cycle following the WAIT0→ZERO transition edge.
- db_rise and db_fall are never high together.

Arithmetic and latency:
- cnt width = max(1, $clog2(N_TICKS)); it never wraps because it is reloaded on WAIT entry.
- Latency from a clean sw edge to db_level change = SYNC_STAGES + 1 + N_TICKS × (timer period) cycles.
- With timer_dp VALUE = V, the timer period is V+1.

Boundary conditions:
- Bounce that lands exactly on the tick that would complete the count aborts the qualification.
- A bounce after completion, while in ONE, starts a new WAIT0 qualification.
- Reset asserted mid-WAIT: the state returns to ZERO with db_level = 0, even if the previous level was 1, and no pulse is emitted.
- Reset release: the first evaluation uses sw_s, so a switch already held high then qualifies normally and produces one db_rise.
- N_TICKS = 1: a single tick in WAIT completes the count.

Decomposition:
- Shared package debounce_pkg holds:
  - the state typedef (ZERO, WAIT1, ONE, WAIT0; 2-bit encoding 00, 01, 11, 10);
  - the default N_TICKS constant.
- One natural sub-module: sync_2ff, a parameterized SYNC_STAGES single-bit synchronizer with the same active-low asynchronous reset.
- timer_dp is instantiated by the parent, not inside this block.

Test Plan:
1. Reset / idle: assert reset low mid-sequence with sw = 1 and tick pulsing → outputs go immediately to db_level = 0, db_rise = 0, db_fall = 0, timer_rst = 1; no pulse appears after release until the full qualification completes.
2. Clean rise: N_TICKS = 4, timer_dp VALUE = 4, sw steps 0→1 at cycle 0 → timer_rst falls at cycle 3, db_level rises at cycle 23, db_rise is high for cycle 23 only, timer_rst returns to 1.
3. Bounce abort: as scenario 2, but sw drops for 1 cycle after 2 ticks → return to ZERO with timer_rst = 1; on sw re-high, a full 4 ticks are again required, and db_rise fires exactly once.
4. Tie case: sw_s falls on the same cycle as the 4th tick in WAIT1 (driven by a bench tick strobe) → state is ZERO, db_level stays 0, no db_rise.
5. Clean fall: from ONE, sw steps 1→0 → db_level = 0 and a single db_fall after the same latency as scenario 2; db_rise is never asserted.
6. N_TICKS = 1 with tick tied high → db_level follows sw_s after SYNC_STAGES + 2 cycles; each sw edge gives exactly one matching pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debounce controller.
// State encoding is Gray-like so db_level is simply bit 1 of the state.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT1 = 2'b01,
        ST_ONE   = 2'b11,
        ST_WAIT0 = 2'b10
    } state_t;

    localparam int N_TICKS_DEFAULT     = 4;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Down-counter width; a single-tick qualification still needs one bit.
    function automatic int cnt_width(input int n_ticks);
        return (n_ticks > 1) ? $clog2(n_ticks) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage single-bit synchronizer for the raw switch input.
// The whole chain clears on reset so no stale level leaks out after release.
module sync_2ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Debounce controller: qualifies each synchronized switch change over N_TICKS
// timer ticks, gating the external timer so it only runs while qualifying.
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int N_TICKS     = N_TICKS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    input  logic tick,
    output logic timer_rst,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int               CNT_W    = cnt_width(N_TICKS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_TICKS - 1);

    logic             w_sw_s;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic r_timer_rst;
    logic r_db_level;
    logic r_db_rise;
    logic r_db_fall;
    logic w_timer_rst_next;
    logic w_db_level_next;
    logic w_db_rise_next;
    logic w_db_fall_next;

    sync_2ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sw),
        .q    (w_sw_s)
    );

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ZERO;
            r_cnt       <= '0;
            r_timer_rst <= 1'b1;
            r_db_level  <= 1'b0;
            r_db_rise   <= 1'b0;
            r_db_fall   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_timer_rst <= w_timer_rst_next;
            r_db_level  <= w_db_level_next;
            r_db_rise   <= w_db_rise_next;
            r_db_fall   <= w_db_fall_next;
        end
    end

    // Next-state decode. A bounce in WAIT wins over a coincident tick.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_ZERO: begin
                if (w_sw_s) begin
                    w_state_next = ST_WAIT1;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            ST_WAIT1: begin
                if (!w_sw_s) begin
                    w_state_next = ST_ZERO;
                end else if (tick) begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_ONE;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
            end
            ST_ONE: begin
                if (!w_sw_s) begin
                    w_state_next = ST_WAIT0;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            ST_WAIT0: begin
                if (w_sw_s) begin
                    w_state_next = ST_ONE;
                end else if (tick) begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_ZERO;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_ZERO;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they change on the transition edge.
    always_comb begin
        w_timer_rst_next = (w_state_next == ST_ZERO) || (w_state_next == ST_ONE);
        w_db_level_next  = (w_state_next == ST_ONE)  || (w_state_next == ST_WAIT0);
        w_db_rise_next   = (r_state == ST_WAIT1) && (w_state_next == ST_ONE);
        w_db_fall_next   = (r_state == ST_WAIT0) && (w_state_next == ST_ZERO);
    end

    assign timer_rst = r_timer_rst;
    assign db_level  = r_db_level;
    assign db_rise   = r_db_rise;
    assign db_fall   = r_db_fall;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm: one instance driven by a timer model
// (VALUE = 4, period 5), one with N_TICKS = 1 and tick tied high.
module tb_debounce_fsm;

    localparam int TV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sw, sw2;
    logic man_mode, man_tick;
    logic [2:0] tcnt;
    logic timer_done, tick_a;

    logic timer_rst, db_level, db_rise, db_fall;
    logic timer_rst2, db_level2, db_rise2, db_fall2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rise_cnt = 0, fall_cnt = 0, rise2_cnt = 0, fall2_cnt = 0, both_cnt = 0;
    int r0, f0;

    debounce_fsm #(.N_TICKS(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(rst_n), .sw(sw), .tick(tick_a),
        .timer_rst(timer_rst), .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall)
    );

    debounce_fsm #(.N_TICKS(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(rst_n), .sw(sw2), .tick(1'b1),
        .timer_rst(timer_rst2), .db_level(db_level2), .db_rise(db_rise2), .db_fall(db_fall2)
    );

    // Behavioural stand-in for timer_dp: counts 0..TV, done while at TV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           tcnt <= '0;
        else if (timer_rst || tcnt == 3'(TV)) tcnt <= '0;
        else                                  tcnt <= tcnt + 3'd1;
    end
    assign timer_done = (tcnt == 3'(TV));
    assign tick_a     = man_mode ? man_tick : timer_done;

    always @(negedge clk) begin
        if (db_rise)  rise_cnt++;
        if (db_fall)  fall_cnt++;
        if (db_rise2) rise2_cnt++;
        if (db_fall2) fall2_cnt++;
        if ((db_rise && db_fall) || (db_rise2 && db_fall2)) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b1; sw = 1'b0; sw2 = 1'b0; man_mode = 1'b0; man_tick = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_timer_rst", timer_rst, 1);
        check("rst_level", db_level, 0);
        check("rst_rise", db_rise, 0);
        check("rst_fall", db_fall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0; goto(5);
        check("idle_level", db_level, 0);
        check("idle_timer_rst", timer_rst, 1);
        $display("txn reset_idle done");

        // Clean rise
        cyc = 0; r0 = rise_cnt; sw = 1'b1;
        goto(2);  check("rise_c2_timer_rst", timer_rst, 1);
        goto(3);  check("rise_c3_timer_rst", timer_rst, 0);
        goto(22); check("rise_c22_level", db_level, 0);
                  check("rise_c22_pulse", db_rise, 0);
        goto(23); check("rise_c23_level", db_level, 1);
                  check("rise_c23_pulse", db_rise, 1);
                  check("rise_c23_timer_rst", timer_rst, 1);
        goto(24); check("rise_c24_pulse", db_rise, 0);
        goto(30); check("rise_count", rise_cnt - r0, 1);
        $display("txn clean_rise done");

        // Clean fall
        cyc = 0; r0 = rise_cnt; f0 = fall_cnt; sw = 1'b0;
        goto(3);  check("fall_c3_timer_rst", timer_rst, 0);
                  check("fall_c3_level", db_level, 1);
        goto(22); check("fall_c22_level", db_level, 1);
        goto(23); check("fall_c23_level", db_level, 0);
                  check("fall_c23_pulse", db_fall, 1);
        goto(24); check("fall_c24_pulse", db_fall, 0);
        goto(30); check("fall_count", fall_cnt - f0, 1);
                  check("fall_no_rise", rise_cnt - r0, 0);
        $display("txn clean_fall done");

        // Tie: bounce lands on the tick that would complete the count
        cyc = 0; r0 = rise_cnt; man_mode = 1'b1; man_tick = 1'b0; sw = 1'b1;
        goto(5);  man_tick = 1'b1;
        goto(8);  man_tick = 1'b0; sw = 1'b0;
        goto(10); man_tick = 1'b1;
                  check("tie_c10_timer_rst", timer_rst, 0);
        goto(11); man_tick = 1'b0;
                  check("tie_c11_timer_rst", timer_rst, 1);
                  check("tie_c11_level", db_level, 0);
                  check("tie_c11_rise", db_rise, 0);
        goto(20); check("tie_rise_count", rise_cnt - r0, 0);
                  check("tie_level_hold", db_level, 0);
        man_mode = 1'b0;
        $display("txn tie_abort done");

        // Bounce abort after two ticks, then full requalification
        cyc = 0; r0 = rise_cnt; sw = 1'b1;
        goto(14); sw = 1'b0;
        goto(15); sw = 1'b1;
        goto(16); check("bnc_c16_timer_rst", timer_rst, 0);
        goto(17); check("bnc_c17_timer_rst", timer_rst, 1);
        goto(18); check("bnc_c18_timer_rst", timer_rst, 0);
        goto(23); check("bnc_c23_level", db_level, 0);
        goto(37); check("bnc_c37_level", db_level, 0);
        goto(38); check("bnc_c38_level", db_level, 1);
                  check("bnc_c38_rise", db_rise, 1);
        goto(45); check("bnc_rise_count", rise_cnt - r0, 1);
        $display("txn bounce_abort done");

        // Reset asserted mid-WAIT0 while level is 1
        cyc = 0; sw = 1'b0;
        goto(10); check("rmw_c10_timer_rst", timer_rst, 0);
                  check("rmw_c10_level", db_level, 1);
        r0 = rise_cnt; f0 = fall_cnt;
        rst_n = 1'b0; sw = 1'b1; man_mode = 1'b1; man_tick = 1'b1;
        #1;
        check("rmw_now_level", db_level, 0);
        check("rmw_now_timer_rst", timer_rst, 1);
        check("rmw_now_rise", db_rise, 0);
        check("rmw_now_fall", db_fall, 0);
        goto(14); man_mode = 1'b0; man_tick = 1'b0;
                  check("rmw_hold_level", db_level, 0);
        cyc = 0; rst_n = 1'b1;
        goto(22); check("rmw_c22_level", db_level, 0);
                  check("rmw_c22_rise_count", rise_cnt - r0, 0);
        goto(23); check("rmw_c23_level", db_level, 1);
                  check("rmw_c23_rise", db_rise, 1);
        goto(28); check("rmw_rise_count", rise_cnt - r0, 1);
                  check("rmw_fall_count", fall_cnt - f0, 0);
        $display("txn reset_mid_wait done");

        // N_TICKS = 1, tick tied high
        cyc = 0; r0 = rise2_cnt; f0 = fall2_cnt; sw2 = 1'b1;
        goto(3);  check("n1_c3_level", db_level2, 0);
                  check("n1_c3_timer_rst", timer_rst2, 0);
        goto(4);  check("n1_c4_level", db_level2, 1);
                  check("n1_c4_rise", db_rise2, 1);
        goto(5);  check("n1_c5_rise", db_rise2, 0);
        cyc = 0; sw2 = 1'b0;
        goto(3);  check("n1f_c3_level", db_level2, 1);
        goto(4);  check("n1f_c4_level", db_level2, 0);
                  check("n1f_c4_fall", db_fall2, 1);
        goto(8);  check("n1_rise_count", rise2_cnt - r0, 1);
                  check("n1_fall_count", fall2_cnt - f0, 1);
        $display("txn n_ticks_1 done");

        check("rise_fall_exclusive", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
